// File: rtl/counter_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// counter_sequencer_pkg
// Shared constants and types for the counter run-control sequencer:
//   STATE_BITS / WRAP_BITS  default widths of counter value and wrap tally
//   ZERO                    counter value after a clear
//   op_t                    command op codes carried on the command bus
//   seq_state_t             sequencer FSM state encodings
// -----------------------------------------------------------------------------
package counter_sequencer_pkg;

  localparam int STATE_BITS = 2;
  localparam int WRAP_BITS  = 8;

  localparam logic [STATE_BITS-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_START = 2'b01,
    OP_STOP  = 2'b10,
    OP_STEP  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_RUN  = 2'b01,
    SEQ_STEP = 2'b10,
    SEQ_DONE = 2'b11
  } seq_state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// -----------------------------------------------------------------------------
// counter_sequencer_if
// Command bus between the host/test command source and the sequencer.
//   cmd_valid  command present            (master -> slave)
//   cmd_op     command op code            (master -> slave)
//   cmd_ready  command taken when valid   (slave  -> master)
// -----------------------------------------------------------------------------
interface counter_sequencer_if;
  import counter_sequencer_pkg::*;

  logic cmd_valid;
  op_t  cmd_op;
  logic cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);

endinterface

// File: rtl/counter_sequencer_wrap_tally.sv
// -----------------------------------------------------------------------------
// counter_sequencer_wrap_tally
// Counts counter wrap-arounds and flags the wrap that reaches the limit.
//   clk, reset   clock and synchronous active-high reset
//   wrap_event   counter goes from all-ones to zero at this edge
//   clear        zero the tally at this edge (wins over wrap_event)
//   wrap_limit   wraps before auto-stop, 0 disables the limit
//   wraps        current tally, wraps modulo 2^WRAP_BITS
//   limit_hit    this edge's wrap makes the tally equal to wrap_limit
// -----------------------------------------------------------------------------
module counter_sequencer_wrap_tally #(
  parameter int WRAP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wrap_event,
  input  logic                 clear,
  input  logic [WRAP_BITS-1:0] wrap_limit,
  output logic [WRAP_BITS-1:0] wraps,
  output logic                 limit_hit
);

  logic [WRAP_BITS-1:0] wraps_inc;

  assign wraps_inc = wraps + WRAP_BITS'(1);

  // Only exact equality stops: a limit lowered below the tally never matches
  // until the tally rolls over to it.
  assign limit_hit = wrap_event && (wrap_limit != '0) && (wraps_inc == wrap_limit);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wraps <= '0;
    end else if (clear) begin
      wraps <= '0;
    end else if (wrap_event) begin
      wraps <= wraps_inc;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
// Run-control FSM for the shared counter core. Takes CLEAR/START/STOP/STEP
// commands, drives the counter's enable and clear, tallies wrap-arounds and
// stops automatically when the programmed wrap limit is reached.
//   clk, reset   clock and synchronous active-high reset
//   cmd          command bus (slave side): cmd_valid, cmd_op, cmd_ready
//   wrap_limit   wraps before auto-stop, 0 = run forever
//   cnt_value    current counter value from the counter core
//   cnt_en       counter advances at the edge where high
//   cnt_clr      counter forced to zero at the edge where high
//   busy         sequencer in RUN or STEP
//   done         one-cycle pulse on entering DONE
//   wraps        wraps since the last CLEAR or START-from-DONE
// -----------------------------------------------------------------------------
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int STATE_BITS = counter_sequencer_pkg::STATE_BITS,
  parameter int WRAP_BITS  = counter_sequencer_pkg::WRAP_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  counter_sequencer_if.slave    cmd,
  input  logic [WRAP_BITS-1:0]  wrap_limit,
  input  logic [STATE_BITS-1:0] cnt_value,
  output logic                  cnt_en,
  output logic                  cnt_clr,
  output logic                  busy,
  output logic                  done,
  output logic [WRAP_BITS-1:0]  wraps
);

  seq_state_t state;
  logic       accept;
  logic       wrap_event;
  logic       limit_hit;
  logic       tally_clear;

  // Enable and busy decode straight from the state register.
  assign cnt_en        = (state == SEQ_RUN) || (state == SEQ_STEP);
  assign busy          = cnt_en;
  assign cmd.cmd_ready = !reset && (state != SEQ_STEP);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // The counter moves from all-ones to zero at this edge.
  assign wrap_event = cnt_en && (cnt_value == '1);

  // A limit hit drops any command accepted at the same edge, so its clear
  // must not reach the tally either.
  assign tally_clear = accept && !limit_hit &&
                       ((cmd.cmd_op == OP_CLEAR) ||
                        ((cmd.cmd_op == OP_START) && (state == SEQ_DONE)));

  counter_sequencer_wrap_tally #(
    .WRAP_BITS (WRAP_BITS)
  ) u_wrap_tally (
    .clk        (clk),
    .reset      (reset),
    .wrap_event (wrap_event),
    .clear      (tally_clear),
    .wrap_limit (wrap_limit),
    .wraps      (wraps),
    .limit_hit  (limit_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEQ_IDLE;
      done    <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      // done and cnt_clr are single-cycle pulses: low unless set below.
      done    <= 1'b0;
      cnt_clr <= 1'b0;
      if (limit_hit) begin
        state <= SEQ_DONE;
        done  <= 1'b1;
      end else begin
        case (state)
          SEQ_IDLE: begin
            if (accept) begin
              case (cmd.cmd_op)
                OP_CLEAR: cnt_clr <= 1'b1;
                OP_START: state   <= SEQ_RUN;
                OP_STEP:  state   <= SEQ_STEP;
                default:  ;
              endcase
            end
          end
          SEQ_RUN: begin
            // The STOP/CLEAR accept cycle still has cnt_en high, so the
            // counter advances once more at that edge.
            if (accept) begin
              case (cmd.cmd_op)
                OP_STOP: state <= SEQ_IDLE;
                OP_CLEAR: begin
                  state   <= SEQ_IDLE;
                  cnt_clr <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          SEQ_STEP: begin
            state <= SEQ_IDLE;
          end
          SEQ_DONE: begin
            if (accept) begin
              case (cmd.cmd_op)
                OP_START: state <= SEQ_RUN;
                OP_CLEAR: begin
                  state   <= SEQ_IDLE;
                  cnt_clr <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          default: state <= SEQ_IDLE;
        endcase
      end
    end
  end

endmodule
